// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the packet-granular AXI4-Stream arbiter.
package axis_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_KEEP_W = 8;
  localparam int unsigned PKT_CNT_W  = 16;

endpackage

// File: rtl/axis_pkt_arbiter_rr_picker.sv
// Combinational round-robin first-one finder: picks the first requester at or
// after ptr_i, wrapping modulo NUM_SRC.
module rr_picker #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin AXI4-Stream arbiter; grant is held until TLAST is accepted.
// Optional per-source packet counters on PKT_CNT when AXIS_PKT_ARB_CNT_EN is defined.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned KEEP_W  = DEF_KEEP_W
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NUM_SRC*DATA_W-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC*KEEP_W-1:0] S_AXIS_TKEEP,
  input  logic [NUM_SRC-1:0]        S_AXIS_TVALID,
  output logic [NUM_SRC-1:0]        S_AXIS_TREADY,
  input  logic [NUM_SRC-1:0]        S_AXIS_TLAST,
  output logic [DATA_W-1:0]         M_AXIS_TDATA,
  output logic [KEEP_W-1:0]         M_AXIS_TKEEP,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic                      M_AXIS_TLAST,
  output logic [NUM_SRC-1:0]        GRANT,
  output logic                      BUSY
`ifdef AXIS_PKT_ARB_CNT_EN
  ,
  output logic [NUM_SRC*PKT_CNT_W-1:0] PKT_CNT
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);

  // Handshake: a beat transfers on a cycle where TVALID and TREADY are both high
  // at the rising ACLK edge; valid never waits on ready.
  arb_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [NUM_SRC-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               locked;
  logic               last_done;

  rr_picker #(
    .NUM_SRC(NUM_SRC),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req_i  (S_AXIS_TVALID),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

  assign locked    = (state_q == ST_LOCKED);
  assign last_done = locked && M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;
  assign GRANT     = grant_q;
  assign BUSY      = locked;

  // Data path is purely combinational from the held grant.
  always_comb begin
    M_AXIS_TDATA  = '0;
    M_AXIS_TKEEP  = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = '0;
    if (locked) begin
      S_AXIS_TREADY = grant_q & {NUM_SRC{M_AXIS_TREADY}};
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (grant_q[i]) begin
          M_AXIS_TDATA  = S_AXIS_TDATA[i*DATA_W +: DATA_W];
          M_AXIS_TKEEP  = S_AXIS_TKEEP[i*KEEP_W +: KEEP_W];
          M_AXIS_TVALID = S_AXIS_TVALID[i];
          M_AXIS_TLAST  = S_AXIS_TLAST[i];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_LOCKED;
          grant_d = pick_gnt;
          idx_d   = pick_idx;
        end
      end
      ST_LOCKED: begin
        if (last_done) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = (idx_q == IDX_W'(NUM_SRC - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef AXIS_PKT_ARB_CNT_EN
  logic [PKT_CNT_W-1:0] cnt_q [NUM_SRC];

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else if (last_done) begin
      cnt_q[idx_q] <= cnt_q[idx_q] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
    assign PKT_CNT[g*PKT_CNT_W +: PKT_CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-granular round-robin arbiter that shares one 64-bit AXI4-Stream master port between NUM_SRC stream sources. It sits upstream of the 64-bit stream processing IP. It grants one source at a time and holds the grant until that source's TLAST beat is accepted, so packets are never interleaved. Data, keep and last are muxed combinationally from the granted source; only the grant decision is registered.

## Interface
Parameters:
- NUM_SRC, default 4: number of source ports; legal range 2..16.
- DATA_W, default 64: TDATA width.
- KEEP_W, default 8: TKEEP width; must equal DATA_W/8.

Ports:
- ACLK  in  1  block clock.
- ARESET  in  1  reset, synchronous, active-high.
- S_AXIS_TDATA  in  NUM_SRC*DATA_W  source data; source i occupies bits [i*DATA_W +: DATA_W].
- S_AXIS_TKEEP  in  NUM_SRC*KEEP_W  source byte keeps, packed the same way.
- S_AXIS_TVALID  in  NUM_SRC  per-source valid.
- S_AXIS_TREADY  out  NUM_SRC  per-source ready.
- S_AXIS_TLAST  in  NUM_SRC  per-source last.
- M_AXIS_TDATA  out  DATA_W  granted data.
- M_AXIS_TKEEP  out  KEEP_W  granted keep.
- M_AXIS_TVALID  out  1  granted valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  granted last.
- GRANT  out  NUM_SRC  one-hot current grant; all zeros when idle.
- BUSY  out  1  high while a packet is in flight (state LOCKED).

## Operation
- Two states:
  - IDLE: no grant. If any S_AXIS_TVALID is high, the round-robin picker selects the first requesting source at or after priority pointer ptr. The FSM registers that source in GRANT and moves to LOCKED.
  - LOCKED: the granted source k is connected to the master port:
    - M_AXIS_TDATA/TKEEP/TLAST/TVALID come from source k.
    - S_AXIS_TREADY[k] equals M_AXIS_TREADY; all other TREADY bits are 0.
  - On the beat where M_AXIS_TVALID, M_AXIS_TREADY and M_AXIS_TLAST are all high: the FSM returns to IDLE, GRANT clears, and ptr becomes (k+1) mod NUM_SRC.
- In IDLE, all M_AXIS outputs are 0 and all S_AXIS_TREADY bits are 0.
- Source k dropping TVALID mid-packet: the grant is held, M_AXIS_TVALID is 0 (a bubble), and other sources keep waiting.
- Requests that are simultaneous with, or arrive during, a packet only compete in the next IDLE cycle.
- A single-beat packet (TLAST on the first beat) is legal: LOCKED lasts one cycle when downstream is ready.
- TKEEP and TDATA pass unmodified; the block never inspects or alters keep bytes.
- Reset mid-packet: the FSM goes to IDLE, GRANT clears, and ptr returns to 0. The downstream sink sees a truncated packet with no TLAST; this is accepted behaviour.

## Timing
- Reset values:
  - M_AXIS_TDATA/TKEEP/TVALID/TLAST = 0; S_AXIS_TREADY = 0; GRANT = 0; BUSY = 0; ptr = 0; state = IDLE.
- Grant latency: TVALID is sampled in IDLE at edge n. GRANT, BUSY and the first M_AXIS_TVALID appear after edge n+1.
- Throughput: one beat per cycle inside a packet. Exactly one idle bubble cycle occurs between consecutive packets, including back-to-back packets from the same source.
- Master outputs depend combinationally on the granted source inputs; there is no register slice on the data path.

## Configuration
- Macro AXIS_PKT_ARB_CNT_EN:
  - Defined: adds output PKT_CNT (NUM_SRC*16 bits). Counter i increments on each accepted TLAST beat from source i, wraps 0xFFFF to 0x0000, and resets to 0.
  - Undefined: the port and counters are absent, and arbitration behaviour is identical.

## Structure
- Package axis_arb_pkg holds:
  - the state enum (IDLE, LOCKED);
  - the DATA_W/KEEP_W defaults;
  - the counter width constant (16).
- Sub-module rr_picker: a combinational round-robin first-one finder. Inputs are req[NUM_SRC] and ptr. Outputs are a one-hot grant and its index. The top level owns the FSM, ptr and the muxes.

## Test plan
- After reset, hold all TVALID = 0 for 5 cycles -> all outputs remain 0 and GRANT = 0.
- Sources 0 and 2 both present 3-beat packets at cycle 0 -> source 0's beats go out on cycles 1-3, a bubble follows on cycle 4, then source 2's beats on cycles 5-7; ptr ends at 3.
- All four sources request continuously -> grants rotate 0,1,2,3,0, and no source is granted twice before the others.
- Granted source drops TVALID for 2 cycles mid-packet while source 1 requests -> M_AXIS_TVALID = 0 for those cycles, GRANT is unchanged, and source 1 sees TREADY = 0.
- M_AXIS_TREADY is low on the TLAST beat for 3 cycles -> TDATA, TKEEP and TLAST are held stable, and the grant releases only after the handshake.
- Assert ARESET mid-packet -> on the next cycle GRANT = 0, M_AXIS_TVALID = 0 and ptr = 0. With AXIS_PKT_ARB_CNT_EN defined, all PKT_CNT = 0.
